dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the RV32I core: the memory end of the mem_read/mem_write/funct3 request interface the decoder drives.
- Holds a word-organised data RAM and serves LB/LH/LW/LBU/LHU and SB/SH/SW with a configurable access latency.
- Stalls the core (PC hold) until each access completes and flags misaligned or illegal accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; word index = addr[31:2] mod DEPTH.
- WAIT_CYCLES, 2, extra wait cycles per access (0 allowed); counter width $clog2(WAIT_CYCLES+1), minimum 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  load request, held until done
- mem_write  in  1  store request, held until done
- funct3  in  3  RV32I width/sign field
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  core must hold PC/regs while high
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid while done=1
- err  out  1  misaligned/illegal flag, valid while done=1
- load_count  out  32  completed-load counter (optional feature)
- store_count  out  32  completed-store counter (optional feature)

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Reset forces state IDLE, count 0, and done, err, rdata, load_count and store_count to 0. RAM contents are not reset.
- req = mem_read | mem_write. stall = (state==IDLE & req) | (state==WAIT); combinational.
- FSM states:
  - IDLE:
    - On req, capture addr, wdata, funct3 and direction.
    - WAIT_CYCLES==0: commit at this edge and go to DONE.
    - Otherwise load count=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: inputs are ignored (the captured copy is used). If count!=0, decrement; else commit and go to DONE.
  - DONE: done=1, stall=0, and the core advances this edge. Go to IDLE unconditionally; the next request is sampled no earlier than the following cycle.
- Latency: request first seen in cycle 0 gives done=1 in cycle WAIT_CYCLES+1.
- Commit (single edge):
  - Loads: read the word and select the lane.
    - LB: sign-extend byte addr[1:0].
    - LBU: zero-extend byte addr[1:0].
    - LH: sign-extend half addr[1].
    - LHU: zero-extend half addr[1].
    - LW: full word.
    - Result is registered into rdata.
  - Stores: byte-enable write.
    - SB: byte lane addr[1:0] gets wdata[7:0].
    - SH: half lane addr[1] gets wdata[15:0].
    - SW: all four lanes get wdata.
    - Other lanes are unchanged.
- Error (err=1 in DONE, rdata=0, no RAM write, same latency):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 not in {000,001,010}.
  - mem_read & mem_write both high.
- rdata and err hold their value outside DONE; the core must only use them while done=1.
- Reset mid-access: state goes to IDLE immediately. A store whose commit edge has not occurred does not write. Counters clear.
- Address bits above the word index are ignored (wrap mod DEPTH).

Optional Feature:
- Macro DMEM_ACCESS_COUNT_EN.
- Defined: load_count and store_count increment by 1 at each non-error commit of their type and wrap at 2^32. Errored accesses are not counted.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- WAIT_CYCLES=2, SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> each access has stall high for cycles 0–2 and done in cycle 3; the load returns rdata=0xDEADBEEF with err=0.
- After the above, SB addr=0x11 wdata=0x80, then LB 0x11 and LBU 0x11 -> LB gives rdata=0xFFFFFF80, LBU gives 0x00000080; word 0x10 reads 0xDEAD80EF.
- LH addr=0x12 after the SB -> rdata=0xFFFFDEAD; LHU addr=0x12 -> 0x0000DEAD.
- Misaligned and illegal requests: LW addr=0x13, SH addr=0x11, mem_read=mem_write=1 -> each gives done with err=1 and rdata=0; word 0x10 stays unchanged.
- WAIT_CYCLES=0 -> done in the cycle after the request, stall high only in the request cycle. Back-to-back SW requests both commit; the DONE→IDLE cycle shows stall=0.
- Assert rst_n low during WAIT of SW addr=0x20 wdata=0x12345678 -> outputs 0, LW 0x20 returns the old value. With DMEM_ACCESS_COUNT_EN, 3 good loads + 1 errored load give load_count=3.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory end of the RV32I mem_read/mem_write/funct3
// request interface. Holds a word-organised RAM, serves LB/LH/LW/LBU/LHU and
// SB/SH/SW after WAIT_CYCLES extra cycles, stalls the core while an access is
// in flight and flags misaligned or illegal accesses.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   mem_read, mem_write request direction, held by the core until done
//   funct3              RV32I width/sign field
//   addr, wdata         byte address and store data
//   stall               core holds PC/regs while high (combinational)
//   done                one-cycle completion pulse
//   rdata, err          load result and error flag, valid while done=1
//   load_count,
//   store_count         completed access counters
//
// Optional feature: define DMEM_ACCESS_COUNT_EN to build the access counters;
// otherwise both counter ports are tied to zero.
//
// state  | meaning
// IDLE   | waiting for a request; captures it on the first request cycle
// WAIT   | counting down the access latency using the captured request
// DONE   | done pulse; core advances, always returns to IDLE
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] load_count,
    output logic [31:0] store_count
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            cap_read, cap_write;
    logic [2:0]      cap_funct3;
    logic [31:0]     cap_addr, cap_wdata;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            cur_read, cur_write;
    logic [2:0]      cur_funct3;
    logic [31:0]     cur_addr, cur_wdata;
    logic [29:0]     word_full;
    logic [AW-1:0]   idx;
    logic            acc_err;
    logic            commit;
    logic [31:0]     word, lane_word, load_data, store_data;
    logic [3:0]      byte_en;

    assign req   = mem_read | mem_write;
    assign stall = ((state == S_IDLE) && req) || (state == S_WAIT);

    // The commit happens in IDLE only for the zero-latency build; there the
    // live inputs are used, otherwise the captured copy.
    assign cur_read   = (state == S_IDLE) ? mem_read  : cap_read;
    assign cur_write  = (state == S_IDLE) ? mem_write : cap_write;
    assign cur_funct3 = (state == S_IDLE) ? funct3    : cap_funct3;
    assign cur_addr   = (state == S_IDLE) ? addr      : cap_addr;
    assign cur_wdata  = (state == S_IDLE) ? wdata     : cap_wdata;

    assign word_full = cur_addr[31:2] % 30'(DEPTH);
    assign idx       = word_full[AW-1:0];

    // rst_n gates the commit so the unreset RAM cannot be written while the
    // rest of the block is held in reset.
    assign commit = rst_n &&
                    (((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (count == '0)));

    always_comb begin
        acc_err = 1'b0;
        if (cur_read && cur_write) begin
            acc_err = 1'b1;
        end else if (cur_read) begin
            if (cur_funct3 == 3'b011 || cur_funct3 == 3'b110 || cur_funct3 == 3'b111)
                acc_err = 1'b1;
        end else if (cur_funct3 != 3'b000 && cur_funct3 != 3'b001 && cur_funct3 != 3'b010) begin
            acc_err = 1'b1;
        end
        if (cur_funct3[1:0] == 2'b01 && cur_addr[0])
            acc_err = 1'b1;
        if (cur_funct3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00)
            acc_err = 1'b1;
    end

    always_comb begin
        word      = mem[idx];
        lane_word = word >> {cur_addr[1:0], 3'b000};
        case (cur_funct3)
            3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_data = {24'h0, lane_word[7:0]};
            3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_data = {16'h0, lane_word[15:0]};
            default: load_data = word;
        endcase
    end

    always_comb begin
        case (cur_funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << cur_addr[1:0];
                store_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{cur_wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = cur_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && cur_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            cap_read   <= 1'b0;
            cap_write  <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            done <= commit;
            if (commit) begin
                err   <= acc_err;
                rdata <= (cur_read && !acc_err) ? load_data : 32'h0;
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cap_read   <= mem_read;
                        cap_write  <= mem_write;
                        cap_funct3 <= funct3;
                        cap_addr   <= addr;
                        cap_wdata  <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_DONE;
                        end else begin
                            count <= CW'(WAIT_CYCLES - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (count != '0)
                        count <= count - CW'(1);
                    else
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (commit && !acc_err) begin
            if (cur_read)
                load_count <= load_count + 32'd1;
            else
                store_count <= store_count + 32'd1;
        end
    end
`else
    assign load_count  = 32'h0;
    assign store_count = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a
// vector table plus reset/counter sequences, and a WAIT_CYCLES=0 instance for
// the zero-latency and back-to-back cases.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        rd0, wr0, rd1, wr1;
    logic [2:0]  f30, f31;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        stall0, done0, err0, stall1, done1, err1;
    logic [31:0] rdata0, lc0, sc0, rdata1, lc1, sc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0), .funct3(f30),
        .addr(addr0), .wdata(wdata0), .stall(stall0), .done(done0), .rdata(rdata0),
        .err(err0), .load_count(lc0), .store_count(sc0));

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .funct3(f31),
        .addr(addr1), .wdata(wdata1), .stall(stall1), .done(done1), .rdata(rdata1),
        .err(err1), .load_count(lc1), .store_count(sc1));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic [2:0] f, logic [31:0] a,
                                logic [31:0] wd, logic c, logic [31:0] e,
                                logic ee, string n);
        vec_t v;
        v.rd = r; v.wr = w; v.f3 = f; v.a = a; v.wd = wd;
        v.chk_rd = c; v.exp_rd = e; v.exp_err = ee; v.name = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issues one request, holds it until done, and reports what was seen.
    task automatic access(input bit sel, input logic r, input logic w,
                          input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_rd, output logic got_err,
                          output int lat, output bit stall_ok, output bit done_stall);
        @(negedge clk);
        if (sel) begin
            rd1 = r; wr1 = w; f31 = f; addr1 = a; wdata1 = wd;
        end else begin
            rd0 = r; wr0 = w; f30 = f; addr0 = a; wdata0 = wd;
        end
        stall_ok = 1'b1; lat = -1; got_rd = '0; got_err = 1'b0; done_stall = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (sel ? done1 : done0) begin
                lat        = c;
                got_rd     = sel ? rdata1 : rdata0;
                got_err    = sel ? err1 : err0;
                done_stall = sel ? stall1 : stall0;
                break;
            end
            if (!(sel ? stall1 : stall0)) stall_ok = 1'b0;
            @(negedge clk);
        end
        if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
        else     begin rd0 = 1'b0; wr0 = 1'b0; end
    endtask

    task automatic run_vec(input bit sel, input vec_t v, input int exp_lat);
        logic [31:0] g_rd;
        logic        g_err;
        int          lat;
        bit          s_ok, d_st;
        access(sel, v.rd, v.wr, v.f3, v.a, v.wd, g_rd, g_err, lat, s_ok, d_st);
        chk({v.name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({v.name, " stall_before_done"}, {31'h0, s_ok}, 32'h1);
        chk({v.name, " stall_in_done"}, {31'h0, d_st}, 32'h0);
        chk({v.name, " err"}, {31'h0, g_err}, {31'h0, v.exp_err});
        if (v.chk_rd) chk({v.name, " rdata"}, g_rd, v.exp_rd);
    endtask

    initial begin
        logic [31:0] exp_lc;
        rst_n = 1'b0;
        rd0 = 0; wr0 = 0; f30 = 0; addr0 = 0; wdata0 = 0;
        rd1 = 0; wr1 = 0; f31 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset done", {31'h0, done0}, 32'h0);
        chk("reset err", {31'h0, err0}, 32'h0);
        chk("reset rdata", rdata0, 32'h0);
        chk("reset stall", {31'h0, stall0}, 32'h0);
        chk("reset load_count", lc0, 32'h0);
        chk("reset store_count", sc0, 32'h0);

        //               rd wr f3      addr          wdata         chk exp_rdata     err
        vecs.push_back(mk(0, 1, 3'b010, 32'h10,      32'hDEADBEEF, 0, 32'h0,        0, "sw_10"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h10,      32'h0,        1, 32'hDEADBEEF, 0, "lw_10"));
        vecs.push_back(mk(0, 1, 3'b000, 32'h11,      32'h80,       0, 32'h0,        0, "sb_11"));
        vecs.push_back(mk(1, 0, 3'b000, 32'h11,      32'h0,        1, 32'hFFFFFF80, 0, "lb_11"));
        vecs.push_back(mk(1, 0, 3'b100, 32'h11,      32'h0,        1, 32'h00000080, 0, "lbu_11"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h10,      32'h0,        1, 32'hDEAD80EF, 0, "lw_10_after_sb"));
        vecs.push_back(mk(1, 0, 3'b001, 32'h12,      32'h0,        1, 32'hFFFFDEAD, 0, "lh_12"));
        vecs.push_back(mk(1, 0, 3'b101, 32'h12,      32'h0,        1, 32'h0000DEAD, 0, "lhu_12"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h13,      32'h0,        1, 32'h0,        1, "lw_misaligned"));
        vecs.push_back(mk(0, 1, 3'b001, 32'h11,      32'h5555,     1, 32'h0,        1, "sh_misaligned"));
        vecs.push_back(mk(1, 1, 3'b010, 32'h10,      32'h0,        1, 32'h0,        1, "rd_and_wr"));
        vecs.push_back(mk(1, 0, 3'b011, 32'h10,      32'h0,        1, 32'h0,        1, "load_f3_011"));
        vecs.push_back(mk(0, 1, 3'b100, 32'h10,      32'h0,        1, 32'h0,        1, "store_f3_100"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h10,      32'h0,        1, 32'hDEAD80EF, 0, "lw_10_unchanged"));
        vecs.push_back(mk(0, 1, 3'b010, 32'h14,      32'h0,        0, 32'h0,        0, "sw_14_zero"));
        vecs.push_back(mk(0, 1, 3'b001, 32'h16,      32'hA5A51234, 0, 32'h0,        0, "sh_16"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h14,      32'h0,        1, 32'h12340000, 0, "lw_14"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h1010,    32'h0,        1, 32'hDEAD80EF, 0, "lw_wrap"));
        vecs.push_back(mk(0, 1, 3'b010, 32'h20,      32'hCAFEF00D, 0, 32'h0,        0, "sw_20_old"));
        vecs.push_back(mk(1, 0, 3'b010, 32'h20,      32'h0,        1, 32'hCAFEF00D, 0, "lw_20"));

        foreach (vecs[i]) run_vec(1'b0, vecs[i], 3);

        // Zero-latency instance: back-to-back stores, the second presented
        // during the DONE cycle of the first.
        @(negedge clk);
        rd1 = 0; wr1 = 1; f31 = 3'b010; addr1 = 32'h40; wdata1 = 32'h11111111;
        #1;
        chk("w0 cycle0 stall", {31'h0, stall1}, 32'h1);
        chk("w0 cycle0 done", {31'h0, done1}, 32'h0);
        @(negedge clk);
        addr1 = 32'h44; wdata1 = 32'h22222222;
        #1;
        chk("w0 first done", {31'h0, done1}, 32'h1);
        chk("w0 first err", {31'h0, err1}, 32'h0);
        chk("w0 done cycle stall", {31'h0, stall1}, 32'h0);
        @(negedge clk);
        #1;
        chk("w0 second req stall", {31'h0, stall1}, 32'h1);
        chk("w0 second req done", {31'h0, done1}, 32'h0);
        @(negedge clk);
        #1;
        chk("w0 second done", {31'h0, done1}, 32'h1);
        chk("w0 second stall", {31'h0, stall1}, 32'h0);
        wr1 = 0;
        run_vec(1'b1, mk(1, 0, 3'b010, 32'h40, 32'h0, 1, 32'h11111111, 0, "w0_lw_40"), 1);
        run_vec(1'b1, mk(1, 0, 3'b010, 32'h44, 32'h0, 1, 32'h22222222, 0, "w0_lw_44"), 1);
        run_vec(1'b1, mk(1, 0, 3'b001, 32'h41, 32'h0, 1, 32'h0, 1, "w0_lh_misaligned"), 1);

        // Reset while a store is waiting: no write may occur.
        @(negedge clk);
        rd0 = 0; wr0 = 1; f30 = 3'b010; addr0 = 32'h20; wdata0 = 32'h12345678;
        @(negedge clk);
        #1;
        chk("pre-reset in wait stall", {31'h0, stall0}, 32'h1);
        rst_n = 1'b0;
        wr0 = 1'b0;
        #1;
        chk("mid reset done", {31'h0, done0}, 32'h0);
        chk("mid reset err", {31'h0, err0}, 32'h0);
        chk("mid reset rdata", rdata0, 32'h0);
        chk("mid reset stall", {31'h0, stall0}, 32'h0);
        chk("mid reset load_count", lc0, 32'h0);
        chk("mid reset store_count", sc0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_vec(1'b0, mk(1, 0, 3'b010, 32'h20, 32'h0, 1, 32'hCAFEF00D, 0, "lw_20_after_reset"), 3);
        run_vec(1'b0, mk(1, 0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD80EF, 0, "cnt_lw_10"), 3);
        run_vec(1'b0, mk(1, 0, 3'b000, 32'h11, 32'h0, 1, 32'hFFFFFF80, 0, "cnt_lb_11"), 3);
        run_vec(1'b0, mk(1, 0, 3'b010, 32'h13, 32'h0, 1, 32'h0, 1, "cnt_lw_err"), 3);
        @(negedge clk);
`ifdef DMEM_ACCESS_COUNT_EN
        exp_lc = 32'd3;
`else
        exp_lc = 32'd0;
`endif
        chk("load_count", lc0, exp_lc);
        chk("store_count", sc0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
